a51_sequencer: RTL and testbench

Phase controller for the A5/1 keystream generator. On a start pulse it captures a 64-bit session key and a 22-bit frame number, then sequences the three LFSRs (R1/R2/R3) through clear, key load, frame load, 100-cycle mixing, and keystream output. It drives per-register clock enables, including majority clocking from the registers' clocking-tap bits, and the serial load bit. It also provides the phase flags and a valid/ready handshake toward the encrypt/decrypt XOR stage.

---
 rtl/a51_sequencer_if.sv | 39 +++
 rtl/a51_sequencer.sv | 176 +++++++++++++++++
 tb/tb_a51_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/a51_sequencer_if.sv
// Handshake and control bundle between the A5/1 phase sequencer, the three
// LFSRs and the downstream keystream XOR stage.
interface a51_sequencer_if #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22
) ();
  logic                  start;
  logic [KEY_BITS-1:0]   key;
  logic [FRAME_BITS-1:0] frame;
  logic                  r1_c;
  logic                  r2_c;
  logic                  r3_c;
  logic                  ks_ready;
  logic                  clr_regs;
  logic                  load_bit;
  logic                  clk_r1;
  logic                  clk_r2;
  logic                  clk_r3;
  logic                  ks_valid;
  logic                  STAGEONE;
  logic                  STAGETWO;
  logic                  STAGETHREE;
  logic                  OUTPUTSTAGE;
  logic [9:0]            bit_index;
  logic                  busy;
  logic                  done;

  modport master (
    output start, key, frame, r1_c, r2_c, r3_c, ks_ready,
    input  clr_regs, load_bit, clk_r1, clk_r2, clk_r3, ks_valid,
    input  STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, bit_index, busy, done
  );

  modport slave (
    input  start, key, frame, r1_c, r2_c, r3_c, ks_ready,
    output clr_regs, load_bit, clk_r1, clk_r2, clk_r3, ks_valid,
    output STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, bit_index, busy, done
  );
endinterface

// File: rtl/a51_sequencer.sv
// A5/1 phase controller: clear, key load, frame load, majority-clocked mixing
// and backpressured keystream output for the three LFSRs.
module a51_sequencer #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int OUT_BITS   = 228
) (
  input logic           C,
  input logic           CLR,
  a51_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_KEY   = 3'd2,
    S_FRAME = 3'd3,
    S_MIX   = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [9:0] KEY_LAST   = 10'(KEY_BITS - 1);
  localparam logic [9:0] FRAME_LAST = 10'(FRAME_BITS - 1);
  localparam logic [9:0] MIX_LAST   = 10'(MIX_CYCLES - 1);
  localparam logic [9:0] OUT_LAST   = 10'(OUT_BITS - 1);
  localparam int         KIDX_W     = $clog2(KEY_BITS);
  localparam int         FIDX_W     = $clog2(FRAME_BITS);

  state_t                state_r, state_s;
  logic [9:0]            bit_index_r, bit_index_s;
  logic [KEY_BITS-1:0]   key_r;
  logic [FRAME_BITS-1:0] frame_r;

  logic       clr_regs_s, load_bit_s, ks_valid_s, busy_s, done_s;
  logic [2:0] clk_en_s;
  logic [3:0] stage_s;

  // Registers whose tap equals the majority of the three taps are clocked.
  function automatic logic [2:0] maj_enables(input logic a, input logic b, input logic c);
    logic m;
    m = (a & b) | (a & c) | (b & c);
    return {a == m, b == m, c == m};
  endfunction

  // State, phase counter and captured session parameters.
  always_ff @(posedge C) begin
    if (CLR) begin
      state_r     <= S_IDLE;
      bit_index_r <= 10'd0;
      key_r       <= '0;
      frame_r     <= '0;
    end else begin
      state_r     <= state_s;
      bit_index_r <= bit_index_s;
      if (state_r == S_IDLE && bus.start) begin
        key_r   <= bus.key;
        frame_r <= bus.frame;
      end else begin
        key_r   <= key_r;
        frame_r <= frame_r;
      end
    end
  end

  // Phase sequencing; bit_index restarts at zero on every phase change.
  always_comb begin
    state_s     = state_r;
    bit_index_s = bit_index_r;
    case (state_r)
      S_IDLE: begin
        bit_index_s = 10'd0;
        if (bus.start) state_s = S_CLEAR;
        else           state_s = S_IDLE;
      end
      S_CLEAR: begin
        state_s     = S_KEY;
        bit_index_s = 10'd0;
      end
      S_KEY: begin
        if (bit_index_r == KEY_LAST) begin
          state_s     = S_FRAME;
          bit_index_s = 10'd0;
        end else begin
          bit_index_s = bit_index_r + 10'd1;
        end
      end
      S_FRAME: begin
        if (bit_index_r == FRAME_LAST) begin
          state_s     = S_MIX;
          bit_index_s = 10'd0;
        end else begin
          bit_index_s = bit_index_r + 10'd1;
        end
      end
      S_MIX: begin
        if (bit_index_r == MIX_LAST) begin
          state_s     = S_OUT;
          bit_index_s = 10'd0;
        end else begin
          bit_index_s = bit_index_r + 10'd1;
        end
      end
      S_OUT: begin
        if (!bus.ks_ready) begin
          bit_index_s = bit_index_r;
        end else if (bit_index_r == OUT_LAST) begin
          state_s     = S_DONE;
          bit_index_s = 10'd0;
        end else begin
          bit_index_s = bit_index_r + 10'd1;
        end
      end
      S_DONE: begin
        state_s     = S_IDLE;
        bit_index_s = 10'd0;
      end
      default: begin
        state_s     = S_IDLE;
        bit_index_s = 10'd0;
      end
    endcase
  end

  // Output decode; a stalled keystream bit freezes all three registers.
  always_comb begin
    clr_regs_s = 1'b0;
    load_bit_s = 1'b0;
    clk_en_s   = 3'b000;
    ks_valid_s = 1'b0;
    stage_s    = 4'b0000;
    done_s     = 1'b0;
    busy_s     = (state_r != S_IDLE);
    case (state_r)
      S_CLEAR: clr_regs_s = 1'b1;
      S_KEY: begin
        stage_s    = 4'b1000;
        clk_en_s   = 3'b111;
        load_bit_s = key_r[bit_index_r[KIDX_W-1:0]];
      end
      S_FRAME: begin
        stage_s    = 4'b0100;
        clk_en_s   = 3'b111;
        load_bit_s = frame_r[bit_index_r[FIDX_W-1:0]];
      end
      S_MIX: begin
        stage_s  = 4'b0010;
        clk_en_s = maj_enables(bus.r1_c, bus.r2_c, bus.r3_c);
      end
      S_OUT: begin
        stage_s    = 4'b0001;
        ks_valid_s = 1'b1;
        if (bus.ks_ready) clk_en_s = maj_enables(bus.r1_c, bus.r2_c, bus.r3_c);
        else              clk_en_s = 3'b000;
      end
      S_DONE:  done_s = 1'b1;
      default: clr_regs_s = 1'b0;
    endcase
  end

  assign bus.clr_regs    = clr_regs_s;
  assign bus.load_bit    = load_bit_s;
  assign bus.clk_r1      = clk_en_s[2];
  assign bus.clk_r2      = clk_en_s[1];
  assign bus.clk_r3      = clk_en_s[0];
  assign bus.ks_valid    = ks_valid_s;
  assign bus.STAGEONE    = stage_s[3];
  assign bus.STAGETWO    = stage_s[2];
  assign bus.STAGETHREE  = stage_s[1];
  assign bus.OUTPUTSTAGE = stage_s[0];
  assign bus.bit_index   = bit_index_r;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;

endmodule

// File: tb/tb_a51_sequencer.sv
// Directed bench for a51_sequencer: reset, full runs, majority table,
// backpressure, mid-run abort and start-while-busy.
module tb_a51_sequencer;

  logic C;
  logic CLR;
  int   checks;
  int   errors;

  a51_sequencer_if ifc ();

  a51_sequencer dut (
    .C   (C),
    .CLR (CLR),
    .bus (ifc.slave)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Enables indexed by {r1_c,r2_c,r3_c}.
  logic [2:0] maj_tab [8] = '{3'b111, 3'b110, 3'b101, 3'b011,
                              3'b011, 3'b101, 3'b110, 3'b111};

  // Observed outputs packed as {clr,load,c1,c2,c3,valid,S1,S2,S3,S4,busy,done,bit_index}.
  function automatic logic [21:0] obs_vec();
    return {ifc.clr_regs, ifc.load_bit, ifc.clk_r1, ifc.clk_r2, ifc.clk_r3,
            ifc.ks_valid, ifc.STAGEONE, ifc.STAGETWO, ifc.STAGETHREE,
            ifc.OUTPUTSTAGE, ifc.busy, ifc.done, ifc.bit_index};
  endfunction

  // Expected outputs at cycle c of a run (start accepted at edge 0, taps 000, ks_ready 1).
  function automatic logic [21:0] exp_vec(input int c, input logic [63:0] k, input logic [21:0] f);
    logic [11:0] fl;
    logic [9:0]  ix;
    fl = 12'd0;
    ix = 10'd0;
    if (c == 1) begin
      fl = 12'b1000_0000_0010;
    end else if (c >= 2 && c <= 65) begin
      ix = 10'(c - 2);
      fl = {1'b0, k[ix[5:0]], 3'b111, 1'b0, 4'b1000, 2'b10};
    end else if (c >= 66 && c <= 87) begin
      ix = 10'(c - 66);
      fl = {1'b0, f[ix[4:0]], 3'b111, 1'b0, 4'b0100, 2'b10};
    end else if (c >= 88 && c <= 187) begin
      ix = 10'(c - 88);
      fl = {2'b00, 3'b111, 1'b0, 4'b0010, 2'b10};
    end else if (c >= 188 && c <= 415) begin
      ix = 10'(c - 188);
      fl = {2'b00, 3'b111, 1'b1, 4'b0001, 2'b10};
    end else if (c == 416) begin
      fl = 12'b0000_0000_0011;
    end
    return {fl, ix};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  // Accepts a start and checks cycles 1..last_c against the latency table.
  task automatic run_cycles(input logic [63:0] k, input logic [21:0] f, input int last_c,
                            output int n_clr, output int n_valid, output int n_done);
    n_clr   = 0;
    n_valid = 0;
    n_done  = 0;
    ifc.key   = k;
    ifc.frame = f;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      if (c > 1) tick();
      #1;
      check($sformatf("run_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c, k, f)));
      if (ifc.clr_regs) n_clr++;
      if (ifc.ks_valid) n_valid++;
      if (ifc.done)     n_done++;
    end
  endtask

  initial begin
    logic [63:0] ka, kb, kc;
    logic [21:0] fa, fb, fc;
    logic [2:0]  taps;
    logic        rdy;
    int          n_clr, n_valid, n_done, acc, stall;

    checks = 0;
    errors = 0;
    ka = 64'hA5C3_0F96_1234_5678;
    fa = 22'h2AB1C5;
    kb = 64'h0123_4567_89AB_CDEF;
    fb = 22'h155E3A;
    kc = 64'hFEDC_0000_BA98_0001;
    fc = 22'h300007;

    CLR          = 1'b1;
    ifc.start    = 1'b1;
    ifc.key      = 64'h8000_0000_0000_0001;
    ifc.frame    = 22'h000003;
    ifc.r1_c     = 1'b0;
    ifc.r2_c     = 1'b0;
    ifc.r3_c     = 1'b0;
    ifc.ks_ready = 1'b1;

    // Reset held two cycles with start high.
    tick(); #1;
    check("reset_1", 32'(obs_vec()), 32'd0);
    tick(); #1;
    check("reset_2", 32'(obs_vec()), 32'd0);
    CLR = 1'b0;

    // Full run with the reference key/frame.
    run_cycles(64'h8000_0000_0000_0001, 22'h000003, 417, n_clr, n_valid, n_done);
    check("full_clr_count", 32'(n_clr), 32'd1);
    check("full_valid_count", 32'(n_valid), 32'd228);
    check("full_done_count", 32'(n_done), 32'd1);

    // Run with start pulses while busy, majority table in MIX, backpressure in OUT.
    ifc.key   = ka;
    ifc.frame = fa;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    #1;
    check("busy_run_c1", 32'(obs_vec()), 32'(exp_vec(1, ka, fa)));
    for (int c = 2; c <= 87; c++) begin
      tick();
      if (c == 7 || c == 70) begin
        ifc.start = 1'b1;
        ifc.key   = ~ka;
        ifc.frame = ~fa;
      end else begin
        ifc.start = 1'b0;
      end
      #1;
      check($sformatf("busy_run_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c, ka, fa)));
    end
    ifc.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      taps = 3'(i);
      {ifc.r1_c, ifc.r2_c, ifc.r3_c} = taps;
      #1;
      check($sformatf("mix_taps%0b_i%0d", taps, i), 32'(obs_vec()),
            32'({2'b00, maj_tab[taps], 1'b0, 4'b0010, 2'b10, 10'(i)}));
    end
    acc   = 0;
    stall = 0;
    for (int it = 0; it < 300 && acc < 228; it++) begin
      tick();
      {ifc.r1_c, ifc.r2_c, ifc.r3_c} = 3'b000;
      rdy = (acc == 10 && stall < 5) ? 1'b0 : 1'b1;
      ifc.ks_ready = rdy;
      #1;
      check($sformatf("out_acc%0d_rdy%0b", acc, rdy), 32'(obs_vec()),
            32'({2'b00, (rdy ? 3'b111 : 3'b000), 1'b1, 4'b0001, 2'b10, 10'(acc)}));
      if (rdy) acc++;
      else     stall++;
    end
    ifc.ks_ready = 1'b1;
    check("out_accepted", 32'(acc), 32'd228);
    check("out_stalls", 32'(stall), 32'd5);
    tick();
    ifc.start = 1'b1;
    ifc.key   = kb;
    #1;
    check("busy_run_done", 32'(obs_vec()), 32'(exp_vec(416, ka, fa)));
    tick();
    ifc.start = 1'b0;
    #1;
    check("start_in_done_idle", 32'(obs_vec()), 32'd0);
    tick(); #1;
    check("start_in_done_stays_idle", 32'(obs_vec()), 32'd0);

    // Abort at MIX bit_index 50, then a fresh run with a new key.
    run_cycles(kb, fb, 138, n_clr, n_valid, n_done);
    CLR = 1'b1;
    tick(); #1;
    check("abort_idle", 32'(obs_vec()), 32'd0);
    CLR = 1'b0;
    tick(); #1;
    check("abort_stays_idle", 32'(obs_vec()), 32'd0);
    run_cycles(kc, fc, 417, n_clr, n_valid, n_done);
    check("restart_clr_count", 32'(n_clr), 32'd1);
    check("restart_valid_count", 32'(n_valid), 32'd228);
    check("restart_done_count", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
